envm_test_sequencer: RTL and testbench

- Self-test controller that sequences the eNVM pattern store and the systolic array through a full SA then TD structural test of every PE.
- Walks each target PE (row, col) and each stored pattern, and hands patterns to the array with a valid/ready handshake.
- Compares each returned partial sum against the eNVM golden answer and builds a per-PE fault map.
- At the end, writes the map back into eNVM one row per cycle over the detection port.

---
 rtl/envm_test_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_envm_test_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/envm_test_sequencer.sv
// ---------------------------------------------------------------------------
// envm_test_sequencer
// Structural self-test controller. For every PE of the systolic array it
// replays the stored stuck-at (SA) patterns and then the transition-delay
// (TD) launch/capture patterns held in eNVM, compares every returned partial
// sum with the eNVM golden answer, records one fault bit per PE and finally
// writes the fault map back into eNVM, one map row per cycle.
// All outputs are registered; they are computed from the next-state values so
// that Moore outputs line up with the state they describe.
// ---------------------------------------------------------------------------
module envm_test_sequencer #(
    parameter int SYSTOLIC_SIZE         = 8,
    parameter int WEIGHT_WIDTH          = 8,
    parameter int ACTIVATION_WIDTH      = 8,
    parameter int ADDR_WIDTH            = $clog2(SYSTOLIC_SIZE),
    parameter int PARTIAL_SUM_WIDTH     = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int SA_TEST_PATTERN_DEPTH = 12,
    parameter int TD_TEST_PATTERN_DEPTH = 18,
    parameter int MAX_ADDR_WIDTH        = $clog2((SA_TEST_PATTERN_DEPTH > TD_TEST_PATTERN_DEPTH) ?
                                                 SA_TEST_PATTERN_DEPTH : TD_TEST_PATTERN_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         fault_found,
    output logic                         test_type,
    output logic                         TD_answer_choose,
    output logic [MAX_ADDR_WIDTH-1:0]    test_counter,
    input  logic [PARTIAL_SUM_WIDTH-1:0] Scan_data_answer,
    output logic [ADDR_WIDTH-1:0]        pe_row_sel,
    output logic [ADDR_WIDTH-1:0]        pe_col_sel,
    output logic                         pat_valid,
    input  logic                         pat_ready,
    input  logic                         res_valid,
    input  logic [PARTIAL_SUM_WIDTH-1:0] res_data,
    output logic                         detection_en,
    output logic [ADDR_WIDTH-1:0]        detection_addr,
    output logic [SYSTOLIC_SIZE-1:0]     single_pe_detection,
    output logic                         row_fault_detection,
    output logic                         column_fault_detection
);

    // FSM encoding
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SA_ISSUE   = 4'd1;
    localparam logic [3:0] S_SA_WAIT    = 4'd2;
    localparam logic [3:0] S_TD_ISSUE   = 4'd3;
    localparam logic [3:0] S_TD_LAUNCH  = 4'd4;
    localparam logic [3:0] S_TD_CAPTURE = 4'd5;
    localparam logic [3:0] S_NEXT_PE    = 4'd6;
    localparam logic [3:0] S_WB         = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam logic [ADDR_WIDTH-1:0]     PE_LAST  = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE = ADDR_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0]     ADDR_ZERO = ADDR_WIDTH'(1'b0);
    localparam logic [MAX_ADDR_WIDTH-1:0] SA_LAST  = MAX_ADDR_WIDTH'(SA_TEST_PATTERN_DEPTH - 1);
    localparam logic [MAX_ADDR_WIDTH-1:0] TD_LAST  = MAX_ADDR_WIDTH'(TD_TEST_PATTERN_DEPTH - 1);
    localparam logic [MAX_ADDR_WIDTH-1:0] CNT_ONE  = MAX_ADDR_WIDTH'(1'b1);
    localparam logic [MAX_ADDR_WIDTH-1:0] CNT_ZERO = MAX_ADDR_WIDTH'(1'b0);

    // map[r][c] is the fault bit of PE(r, c)
    typedef logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0] fault_map_t;

    logic [3:0]                state_r;
    logic [3:0]                state_nxt_s;
    logic                      fail_r;
    logic                      fail_nxt_s;
    fault_map_t                map_r;
    fault_map_t                map_nxt_s;
    logic [MAX_ADDR_WIDTH-1:0] cnt_nxt_s;
    logic [ADDR_WIDTH-1:0]     row_nxt_s;
    logic [ADDR_WIDTH-1:0]     col_nxt_s;
    logic [ADDR_WIDTH-1:0]     wb_addr_nxt_s;
    logic                      fault_nxt_s;
    logic                      mismatch_s;
    logic                      in_wb_s;
    logic [SYSTOLIC_SIZE-1:0]  wb_row_s;
    logic                      wb_col_all_s;

    // AND of the fault bits of one column across every row of the map
    function automatic logic column_all_faulty(input fault_map_t map,
                                               input logic [ADDR_WIDTH-1:0] col);
        logic acc;
        acc = 1'b1;
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            acc = acc & map[r][col];
        end
        return acc;
    endfunction

    // Full-width comparison: any differing bit of the partial sum is a fault
    assign mismatch_s = (res_data != Scan_data_answer);

    // Next-state, counter, fail-flag and fault-map update logic
    always_comb begin
        state_nxt_s   = state_r;
        fail_nxt_s    = fail_r;
        map_nxt_s     = map_r;
        cnt_nxt_s     = test_counter;
        row_nxt_s     = pe_row_sel;
        col_nxt_s     = pe_col_sel;
        wb_addr_nxt_s = detection_addr;
        fault_nxt_s   = fault_found;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    map_nxt_s   = {(SYSTOLIC_SIZE*SYSTOLIC_SIZE){1'b0}};
                    fail_nxt_s  = 1'b0;
                    fault_nxt_s = 1'b0;
                    row_nxt_s   = ADDR_ZERO;
                    col_nxt_s   = ADDR_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = S_SA_ISSUE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SA_ISSUE: begin
                if (pat_ready) begin
                    state_nxt_s = S_SA_WAIT;
                end else begin
                    state_nxt_s = S_SA_ISSUE;
                end
            end
            S_SA_WAIT: begin
                if (res_valid) begin
                    fail_nxt_s = fail_r | mismatch_s;
                    if (test_counter == SA_LAST) begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = S_TD_ISSUE;
                    end else begin
                        cnt_nxt_s   = test_counter + CNT_ONE;
                        state_nxt_s = S_SA_ISSUE;
                    end
                end else begin
                    state_nxt_s = S_SA_WAIT;
                end
            end
            S_TD_ISSUE: begin
                if (pat_ready) begin
                    state_nxt_s = S_TD_LAUNCH;
                end else begin
                    state_nxt_s = S_TD_ISSUE;
                end
            end
            S_TD_LAUNCH: begin
                if (res_valid) begin
                    fail_nxt_s  = fail_r | mismatch_s;
                    state_nxt_s = S_TD_CAPTURE;
                end else begin
                    state_nxt_s = S_TD_LAUNCH;
                end
            end
            S_TD_CAPTURE: begin
                if (res_valid) begin
                    fail_nxt_s = fail_r | mismatch_s;
                    if (test_counter == TD_LAST) begin
                        state_nxt_s = S_NEXT_PE;
                    end else begin
                        cnt_nxt_s   = test_counter + CNT_ONE;
                        state_nxt_s = S_TD_ISSUE;
                    end
                end else begin
                    state_nxt_s = S_TD_CAPTURE;
                end
            end
            S_NEXT_PE: begin
                map_nxt_s[pe_row_sel][pe_col_sel] = fail_r;
                fail_nxt_s  = 1'b0;
                cnt_nxt_s   = CNT_ZERO;
                fault_nxt_s = |map_nxt_s;
                if ((pe_row_sel == PE_LAST) && (pe_col_sel == PE_LAST)) begin
                    row_nxt_s     = ADDR_ZERO;
                    col_nxt_s     = ADDR_ZERO;
                    wb_addr_nxt_s = ADDR_ZERO;
                    state_nxt_s   = S_WB;
                end else if (pe_col_sel == PE_LAST) begin
                    col_nxt_s   = ADDR_ZERO;
                    row_nxt_s   = pe_row_sel + ADDR_ONE;
                    state_nxt_s = S_SA_ISSUE;
                end else begin
                    col_nxt_s   = pe_col_sel + ADDR_ONE;
                    state_nxt_s = S_SA_ISSUE;
                end
            end
            S_WB: begin
                if (detection_addr == PE_LAST) begin
                    wb_addr_nxt_s = ADDR_ZERO;
                    state_nxt_s   = S_DONE;
                end else begin
                    wb_addr_nxt_s = detection_addr + ADDR_ONE;
                    state_nxt_s   = S_WB;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Write-back row selection; the map used already contains the last PE's bit
    always_comb begin
        in_wb_s      = (state_nxt_s == S_WB);
        wb_row_s     = {SYSTOLIC_SIZE{1'b0}};
        wb_col_all_s = 1'b0;
        if (in_wb_s) begin
            wb_row_s     = map_nxt_s[wb_addr_nxt_s];
            wb_col_all_s = column_all_faulty(map_nxt_s, wb_addr_nxt_s);
        end else begin
            wb_row_s     = {SYSTOLIC_SIZE{1'b0}};
            wb_col_all_s = 1'b0;
        end
    end

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r                <= S_IDLE;
            fail_r                 <= 1'b0;
            map_r                  <= {(SYSTOLIC_SIZE*SYSTOLIC_SIZE){1'b0}};
            busy                   <= 1'b0;
            done                   <= 1'b0;
            fault_found            <= 1'b0;
            test_type              <= 1'b0;
            TD_answer_choose       <= 1'b0;
            test_counter           <= CNT_ZERO;
            pe_row_sel             <= ADDR_ZERO;
            pe_col_sel             <= ADDR_ZERO;
            pat_valid              <= 1'b0;
            detection_en           <= 1'b0;
            detection_addr         <= ADDR_ZERO;
            single_pe_detection    <= {SYSTOLIC_SIZE{1'b0}};
            row_fault_detection    <= 1'b0;
            column_fault_detection <= 1'b0;
        end else begin
            state_r                <= state_nxt_s;
            fail_r                 <= fail_nxt_s;
            map_r                  <= map_nxt_s;
            busy                   <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
            done                   <= (state_nxt_s == S_DONE);
            fault_found            <= fault_nxt_s;
            test_type              <= (state_nxt_s == S_TD_ISSUE) || (state_nxt_s == S_TD_LAUNCH) ||
                                      (state_nxt_s == S_TD_CAPTURE);
            TD_answer_choose       <= (state_nxt_s == S_TD_CAPTURE);
            test_counter           <= cnt_nxt_s;
            pe_row_sel             <= row_nxt_s;
            pe_col_sel             <= col_nxt_s;
            pat_valid              <= (state_nxt_s == S_SA_ISSUE) || (state_nxt_s == S_TD_ISSUE);
            detection_en           <= in_wb_s;
            detection_addr         <= wb_addr_nxt_s;
            single_pe_detection    <= wb_row_s;
            row_fault_detection    <= in_wb_s & (&wb_row_s);
            column_fault_detection <= wb_col_all_s;
        end
    end

endmodule

// File: tb/tb_envm_test_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for envm_test_sequencer (N=2, two SA and two TD patterns per PE).
// The bench plays eNVM (golden answers as a function of the requested
// pattern) and the systolic array (handshake, latency, injected faults).
// Expected fault maps are derived from the injected faults; a monitor pops
// expectations from queues whenever the DUT presents a handshake, a result
// strobe, a write-back row or the done pulse.
// ---------------------------------------------------------------------------
module tb_envm_test_sequencer;

    localparam int N   = 2;
    localparam int AW  = 1;
    localparam int MAW = 1;
    localparam int PSW = 8 + 8 + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           busy, done, fault_found, test_type, TD_answer_choose;
    logic [MAW-1:0] test_counter;
    logic [PSW-1:0] Scan_data_answer;
    logic [AW-1:0]  pe_row_sel, pe_col_sel;
    logic           pat_valid, pat_ready, res_valid;
    logic [PSW-1:0] res_data;
    logic           detection_en;
    logic [AW-1:0]  detection_addr;
    logic [N-1:0]   single_pe_detection;
    logic           row_fault_detection, column_fault_detection;

    envm_test_sequencer #(
        .SYSTOLIC_SIZE(N), .WEIGHT_WIDTH(8), .ACTIVATION_WIDTH(8),
        .SA_TEST_PATTERN_DEPTH(2), .TD_TEST_PATTERN_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .fault_found(fault_found), .test_type(test_type),
        .TD_answer_choose(TD_answer_choose), .test_counter(test_counter),
        .Scan_data_answer(Scan_data_answer), .pe_row_sel(pe_row_sel),
        .pe_col_sel(pe_col_sel), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .res_valid(res_valid), .res_data(res_data), .detection_en(detection_en),
        .detection_addr(detection_addr), .single_pe_detection(single_pe_detection),
        .row_fault_detection(row_fault_detection),
        .column_fault_detection(column_fault_detection)
    );

    always #5 clk = ~clk;

    typedef struct { int tt; int cnt; int r; int c; } hs_t;
    typedef struct { int tt; int tac; } rs_t;
    typedef struct { int addr; logic [N-1:0] bits; bit rowf; bit colf; } wb_t;

    int  vectors = 0;
    int  miscompares = 0;
    int  salt = 0;
    bit  res_real = 1'b0;
    bit  exp_ff;
    bit  faults [N][N][3][2];   // [row][col][phase: 0 SA, 1 launch, 2 capture][pattern]
    hs_t hs_q[$];
    rs_t res_q[$];
    wb_t wb_q[$];
    bit  done_q[$];

    // Golden answer for a pattern; distinct for every (type, choose, index, row, col)
    function automatic logic [PSW-1:0] golden(input int s, input int tt, input int tac,
                                              input int cnt, input int r, input int c);
        int v;
        v = s + tt * 7919 + tac * 104729 + cnt * 1237 + r * 331 + c * 97;
        return v[PSW-1:0];
    endfunction

    // eNVM model: combinational read addressed by the sequencer
    always_comb begin
        Scan_data_answer = golden(salt, int'(test_type), int'(TD_answer_choose),
                                  int'(test_counter), int'(pe_row_sel), int'(pe_col_sel));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    always @(negedge clk) begin
        if (rst_n) begin
            if (pat_valid) begin
                if (hs_q.size() == 0) begin
                    chk("unexpected_pat_valid", 32'd1, 32'd0);
                end else begin
                    chk("hs_test_type", 32'(test_type), 32'(hs_q[0].tt));
                    chk("hs_test_counter", 32'(test_counter), 32'(hs_q[0].cnt));
                    chk("hs_pe_row", 32'(pe_row_sel), 32'(hs_q[0].r));
                    chk("hs_pe_col", 32'(pe_col_sel), 32'(hs_q[0].c));
                    if (pat_ready) void'(hs_q.pop_front());
                end
            end
            if (res_valid && res_real) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    chk("res_test_type", 32'(test_type), 32'(res_q[0].tt));
                    chk("res_answer_choose", 32'(TD_answer_choose), 32'(res_q[0].tac));
                    void'(res_q.pop_front());
                end
            end
            if (detection_en) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_detection_en", 32'd1, 32'd0);
                end else begin
                    chk("wb_addr", 32'(detection_addr), 32'(wb_q[0].addr));
                    chk("wb_bits", 32'(single_pe_detection), 32'(wb_q[0].bits));
                    chk("wb_row_fault", 32'(row_fault_detection), 32'(wb_q[0].rowf));
                    chk("wb_col_fault", 32'(column_fault_detection), 32'(wb_q[0].colf));
                    void'(wb_q.pop_front());
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("done_after_all_wb", 32'(wb_q.size()), 32'd0);
                    chk("done_fault_found", 32'(fault_found), 32'(done_q[0]));
                    chk("done_busy_low", 32'(busy), 32'd0);
                    void'(done_q.pop_front());
                end
            end
        end
    end

    task automatic set_faults(input int scen);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int ph = 0; ph < 3; ph++)
                    for (int p = 0; p < 2; p++) begin
                        case (scen)
                            1: faults[r][c][ph][p] = (r == 1 && c == 0 && ph == 0 && p == 1);
                            2: faults[r][c][ph][p] = (r == 0 && c == 1 && ph == 2 && p == 0);
                            3: faults[r][c][ph][p] = (r == 0 || c == 1);
                            4, 5, 6: faults[r][c][ph][p] = ($urandom_range(0, 7) == 0);
                            default: faults[r][c][ph][p] = 1'b0;
                        endcase
                    end
    endtask

    // Reference model: a PE is faulty if any of its results was corrupted
    task automatic plan_run();
        bit m [N][N];
        exp_ff = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                m[r][c] = 1'b0;
                for (int ph = 0; ph < 3; ph++)
                    for (int p = 0; p < 2; p++)
                        if (faults[r][c][ph][p]) m[r][c] = 1'b1;
                if (m[r][c]) exp_ff = 1'b1;
            end
        for (int a = 0; a < N; a++) begin
            wb_t e;
            e.addr = a;
            e.rowf = 1'b1;
            e.colf = 1'b1;
            for (int c = 0; c < N; c++) begin
                e.bits[c] = m[a][c];
                if (!m[a][c]) e.rowf = 1'b0;
            end
            for (int r = 0; r < N; r++)
                if (!m[r][a]) e.colf = 1'b0;
            wb_q.push_back(e);
        end
        done_q.push_back(exp_ff);
    endtask

    // Array side: present one pattern slot with optional backpressure and stray traffic
    task automatic issue(input int tt, input int cnt, input int r, input int c, input bit first);
        int  n = 0;
        int  bp;
        bit  stray;
        hs_t e;
        while (!pat_valid && n < 20) begin
            tick();
            n++;
        end
        if (!pat_valid) begin
            chk("pat_valid_timeout", 32'd0, 32'd1);
            return;
        end
        e.tt = tt; e.cnt = cnt; e.r = r; e.c = c;
        hs_q.push_back(e);
        bp    = first ? 5 : $urandom_range(0, 2);
        stray = ($urandom_range(0, 1) == 1);
        for (int k = 0; k < bp; k++) begin
            pat_ready = 1'b0;
            res_valid = stray;
            res_data  = PSW'($urandom);
            start     = stray ? ($urandom_range(0, 1) == 1) : 1'b0;
            tick();
        end
        start     = 1'b0;
        pat_ready = 1'b1;
        res_valid = stray;
        res_data  = ~golden(salt, tt, 0, cnt, r, c);
        tick();
        pat_ready = 1'b0;
        res_valid = 1'b0;
    endtask

    // Array side: return one partial sum, corrupted if a fault is injected for it
    task automatic deliver(input int ph, input int p, input int r, input int c);
        int  tt  = (ph == 0) ? 0 : 1;
        int  tac = (ph == 2) ? 1 : 0;
        int  d   = $urandom_range(0, 2);
        rs_t e;
        logic [PSW-1:0] one = 1;
        for (int k = 0; k < d; k++) tick();
        res_data = golden(salt, tt, tac, p, r, c);
        if (faults[r][c][ph][p]) res_data = res_data ^ (one << $urandom_range(0, PSW - 1));
        e.tt = tt; e.tac = tac;
        res_q.push_back(e);
        res_valid = 1'b1;
        res_real  = 1'b1;
        tick();
        res_valid = 1'b0;
        res_real  = 1'b0;
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs",
            32'({busy, done, fault_found, test_type, TD_answer_choose, test_counter,
                 pe_row_sel, pe_col_sel, pat_valid, detection_en, detection_addr,
                 single_pe_detection, row_fault_detection, column_fault_detection}), 32'd0);
        hs_q.delete(); res_q.delete(); wb_q.delete(); done_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("reset_mid_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_seq(input int scen, input bit do_reset);
        bit first = 1'b1;
        int n = 0;
        set_faults(scen);
        salt = int'($urandom_range(0, 65535));
        plan_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("pat_valid_after_start", 32'(pat_valid), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                for (int p = 0; p < 2; p++) begin
                    issue(0, p, r, c, first);
                    first = 1'b0;
                    deliver(0, p, r, c);
                end
                for (int p = 0; p < 2; p++) begin
                    issue(1, p, r, c, 1'b0);
                    deliver(1, p, r, c);
                    if (do_reset && r == 1 && c == 0 && p == 0) begin
                        mid_reset();
                        return;
                    end
                    deliver(2, p, r, c);
                end
            end
        while (done_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (done_q.size() != 0) begin
            chk("done_timeout", 32'(done_q.size()), 32'd0);
            wb_q.delete();
            done_q.delete();
        end
        tick(); tick(); tick();
        chk("fault_found_held", 32'(fault_found), 32'(exp_ff));
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pat_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        #1;
        chk("reset_outputs",
            32'({busy, done, fault_found, test_type, TD_answer_choose, test_counter,
                 pe_row_sel, pe_col_sel, pat_valid, detection_en, detection_addr,
                 single_pe_detection, row_fault_detection, column_fault_detection}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        run_seq(0, 1'b0);   // fault-free
        run_seq(1, 1'b0);   // PE(1,0) SA pattern 1
        run_seq(2, 1'b0);   // PE(0,1) TD capture of pattern 0
        run_seq(3, 1'b0);   // whole row 0 and column 1
        run_seq(4, 1'b0);   // random faults
        run_seq(5, 1'b1);   // reset during TD capture of PE(1,0)
        run_seq(6, 1'b0);   // fresh complete run after reset
        chk("hs_queue_drained", 32'(hs_q.size()), 32'd0);
        chk("res_queue_drained", 32'(res_q.size()), 32'd0);
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
